// File: rtl/mt_pkg.sv
// Shared types and helpers for the multithreaded core's hardware-thread scheduler.
package mt_pkg;

  typedef enum logic {
    READY = 1'b0,
    WAIT  = 1'b1
  } thread_state_e;

  localparam int PC_INC = 4;

  // Thread-id width, never narrower than one bit even for a single-bit index.
  function automatic int tidWidth(input int numThreads);
    return (numThreads <= 2) ? 1 : $clog2(numThreads);
  endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Event inputs (advance/redirect/miss/done) and fetch-selection outputs of the thread scheduler.
interface thread_scheduler_if
  import mt_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32
) ();
  localparam int TID_W = tidWidth(NUM_THREADS);

  logic             advance;
  logic             redirect_valid;
  logic [TID_W-1:0] redirect_tid;
  logic [XLEN-1:0]  redirect_pc;
  logic             miss_valid;
  logic [TID_W-1:0] miss_tid;
  logic [XLEN-1:0]  miss_pc;
  logic             done_valid;
  logic [TID_W-1:0] done_tid;
  logic             fetch_valid;
  logic [TID_W-1:0] fetch_tid;
  logic [XLEN-1:0]  fetch_pc;
  logic             switch_pulse;
  logic [TID_W-1:0] flush_tid;
  logic             all_waiting;

  modport master (
    output advance, redirect_valid, redirect_tid, redirect_pc,
           miss_valid, miss_tid, miss_pc, done_valid, done_tid,
    input  fetch_valid, fetch_tid, fetch_pc, switch_pulse, flush_tid, all_waiting
  );

  modport slave (
    input  advance, redirect_valid, redirect_tid, redirect_pc,
           miss_valid, miss_tid, miss_pc, done_valid, done_tid,
    output fetch_valid, fetch_tid, fetch_pc, switch_pulse, flush_tid, all_waiting
  );
endinterface

// File: rtl/rr_thread_picker.sv
// Combinational round-robin search: first READY thread at the smallest distance from start (distance 0 = start).
module rr_thread_picker #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = 2
) (
  input  logic [NUM_THREADS-1:0] ready,
  input  logic [TID_W-1:0]       start,
  output logic                   found,
  output logic [TID_W-1:0]       index
);
  localparam int SW = TID_W + 1;

  logic [SW-1:0] cand;

  // Walk from the farthest distance down so the nearest READY thread is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int d = NUM_THREADS - 1; d >= 0; d--) begin
      cand = {1'b0, start} + SW'(d);
      if (cand >= SW'(NUM_THREADS)) cand = cand - SW'(NUM_THREADS);
      if (ready[cand[TID_W-1:0]]) begin
        found = 1'b1;
        index = cand[TID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/thread_scheduler.sv
// Switch-on-miss hardware-thread scheduler for NUM_THREADS threads.
// Optional THREAD_STALL_COUNT_EN adds per-thread saturating WAIT-cycle counters on stall_count.
module thread_scheduler
  import mt_pkg::*;
#(
  parameter int              NUM_THREADS = 4,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STRIDE   = 32'h0000_0400
) (
  input  logic clk,
  input  logic nReset,
  thread_scheduler_if.slave bus
`ifdef THREAD_STALL_COUNT_EN
  ,
  output logic [NUM_THREADS*16-1:0] stall_count
`endif
);
  localparam int TID_W = tidWidth(NUM_THREADS);

  thread_state_e    stateQ    [NUM_THREADS];
  thread_state_e    stateNext [NUM_THREADS];
  logic [XLEN-1:0]  pcQ       [NUM_THREADS];
  logic [XLEN-1:0]  pcNext    [NUM_THREADS];
  logic [NUM_THREADS-1:0] readyNext;

  logic             fetchValidQ, switchQ, allWaitingQ;
  logic [TID_W-1:0] fetchTidQ, flushTidQ;
  logic [XLEN-1:0]  fetchPcQ;

  logic             pickFound;
  logic [TID_W-1:0] pickTid, selTid;

  // Per-thread event priority: miss over redirect over advance; a same-cycle miss beats done.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      pcNext[t]    = pcQ[t];
      stateNext[t] = stateQ[t];
      if (bus.miss_valid && bus.miss_tid == TID_W'(t)) begin
        pcNext[t]    = bus.miss_pc;
        stateNext[t] = WAIT;
      end else begin
        if (bus.redirect_valid && bus.redirect_tid == TID_W'(t))
          pcNext[t] = bus.redirect_pc;
        else if (bus.advance && fetchValidQ && fetchTidQ == TID_W'(t))
          pcNext[t] = pcQ[t] + XLEN'(PC_INC);
        if (bus.done_valid && bus.done_tid == TID_W'(t))
          stateNext[t] = READY;
      end
      readyNext[t] = (stateNext[t] == READY);
    end
  end

  rr_thread_picker #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) picker (
    .ready (readyNext),
    .start (fetchTidQ),
    .found (pickFound),
    .index (pickTid)
  );

  assign selTid = pickFound ? pickTid : fetchTidQ;

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        stateQ[t] <= READY;
        pcQ[t]    <= RESET_PC + XLEN'(t) * PC_STRIDE;
      end
      fetchValidQ <= 1'b1;
      fetchTidQ   <= '0;
      fetchPcQ    <= RESET_PC;
      switchQ     <= 1'b0;
      flushTidQ   <= '0;
      allWaitingQ <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        stateQ[t] <= stateNext[t];
        pcQ[t]    <= pcNext[t];
      end
      fetchValidQ <= pickFound;
      fetchTidQ   <= selTid;
      fetchPcQ    <= pcNext[selTid];
      switchQ     <= (selTid != fetchTidQ);
      if (selTid != fetchTidQ) flushTidQ <= fetchTidQ;
      allWaitingQ <= !pickFound;
    end
  end

  assign bus.fetch_valid  = fetchValidQ;
  assign bus.fetch_tid    = fetchTidQ;
  assign bus.fetch_pc     = fetchPcQ;
  assign bus.switch_pulse = switchQ;
  assign bus.flush_tid    = flushTidQ;
  assign bus.all_waiting  = allWaitingQ;

`ifdef THREAD_STALL_COUNT_EN
  logic [15:0] stallQ [NUM_THREADS];

  // Counters track registered WAIT state and stick at all-ones.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      for (int t = 0; t < NUM_THREADS; t++) stallQ[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++)
        if (stateQ[t] == WAIT && stallQ[t] != 16'hFFFF) stallQ[t] <= stallQ[t] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_THREADS; g++) begin : genStall
    assign stall_count[g*16 +: 16] = stallQ[g];
  end
`endif
endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler (NUM_THREADS=4); stall counters checked when THREAD_STALL_COUNT_EN is defined.
module tb_thread_scheduler;
  import mt_pkg::*;

  typedef struct {
    bit        adv;
    bit        rv;
    bit [1:0]  rtid;
    bit [31:0] rpc;
    bit        mv;
    bit [1:0]  mtid;
    bit [31:0] mpc;
    bit        dv;
    bit [1:0]  dtid;
  } stim_t;

  typedef struct {
    string     name;
    bit        fv;
    bit [1:0]  tid;
    bit [31:0] pc;
    bit        chkPc;
    bit        sw;
    bit [1:0]  ft;
    bit        aw;
    bit        chkStall;
    bit [63:0] stall;
  } exp_t;

  logic clk;
  logic nReset;
  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];

  thread_scheduler_if #(.NUM_THREADS(4), .XLEN(32)) bus ();

`ifdef THREAD_STALL_COUNT_EN
  logic [63:0] stallCount;
`endif

  thread_scheduler #(
    .NUM_THREADS (4),
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .PC_STRIDE   (32'h0000_0400)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
`ifdef THREAD_STALL_COUNT_EN
    ,
    .stall_count (stallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(bit adv, bit rv, bit [1:0] rtid, bit [31:0] rpc,
                               bit mv, bit [1:0] mtid, bit [31:0] mpc, bit dv, bit [1:0] dtid);
    stim_t s;
    s.adv = adv; s.rv = rv; s.rtid = rtid; s.rpc = rpc;
    s.mv = mv; s.mtid = mtid; s.mpc = mpc; s.dv = dv; s.dtid = dtid;
    return s;
  endfunction

  function automatic exp_t ex(bit fv, bit [1:0] tid, bit [31:0] pc, bit chkPc,
                              bit sw, bit [1:0] ft, bit aw);
    exp_t e;
    e.name = ""; e.fv = fv; e.tid = tid; e.pc = pc; e.chkPc = chkPc;
    e.sw = sw; e.ft = ft; e.aw = aw; e.chkStall = 1'b0; e.stall = '0;
    return e;
  endfunction

  task automatic driveInputs(input stim_t s);
    bus.advance        = s.adv;
    bus.redirect_valid = s.rv;
    bus.redirect_tid   = s.rtid;
    bus.redirect_pc    = s.rpc;
    bus.miss_valid     = s.mv;
    bus.miss_tid       = s.mtid;
    bus.miss_pc        = s.mpc;
    bus.done_valid     = s.dv;
    bus.done_tid       = s.dtid;
  endtask

  // Drive one cycle's events on the falling edge and queue the outputs expected after the next rising edge.
  task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
    @(negedge clk);
    driveInputs(s);
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic bad;
    bad = (bus.fetch_valid !== e.fv) || (bus.fetch_tid !== e.tid) ||
          (e.chkPc && bus.fetch_pc !== e.pc) || (bus.switch_pulse !== e.sw) ||
          (bus.flush_tid !== e.ft) || (bus.all_waiting !== e.aw);
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b tid=%0d pc=%h sw=%0b flush=%0d aw=%0b, expected valid=%0b tid=%0d pc=%h(chk=%0b) sw=%0b flush=%0d aw=%0b",
               e.name, bus.fetch_valid, bus.fetch_tid, bus.fetch_pc, bus.switch_pulse,
               bus.flush_tid, bus.all_waiting, e.fv, e.tid, e.pc, e.chkPc, e.sw, e.ft, e.aw);
    end
`ifdef THREAD_STALL_COUNT_EN
    if (e.chkStall) begin
      checks++;
      if (stallCount !== e.stall) begin
        errors++;
        $display("[TB] FAIL %s stall_count: got %h, expected %h", e.name, stallCount, e.stall);
      end
    end
`endif
  endtask

  // Monitor: pops one expectation per rising edge, decoupled from the stimulus process.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    exp_t  e;
    idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nReset = 1'b1;
    driveInputs(idle);
    repeat (2) @(negedge clk);

    applyStimulus("reset", idle, ex(1, 0, 32'h0, 1, 0, 0, 0));
    @(negedge clk);
    nReset = 1'b0;

    applyStimulus("adv0", st(1, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 0, 32'h4, 1, 0, 0, 0));
    applyStimulus("adv1", st(1, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 0, 32'h8, 1, 0, 0, 0));
    applyStimulus("adv2", st(1, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 0, 32'hC, 1, 0, 0, 0));
    applyStimulus("miss0", st(1, 0, 0, 0, 1, 0, 32'h10, 0, 0), ex(1, 1, 32'h400, 1, 1, 0, 0));
    applyStimulus("done0_adv1", st(1, 0, 0, 0, 0, 0, 0, 1, 0), ex(1, 1, 32'h404, 1, 0, 0, 0));
    applyStimulus("miss1", st(0, 0, 0, 0, 1, 1, 32'h408, 0, 0), ex(1, 2, 32'h800, 1, 1, 1, 0));
    applyStimulus("miss2", st(0, 0, 0, 0, 1, 2, 32'h820, 0, 0), ex(1, 3, 32'hC00, 1, 1, 2, 0));
    applyStimulus("miss3", st(0, 0, 0, 0, 1, 3, 32'hC40, 0, 0), ex(1, 0, 32'h10, 1, 1, 3, 0));
    applyStimulus("miss0_allwait", st(0, 0, 0, 0, 1, 0, 32'h14, 0, 0), ex(0, 0, 32'h0, 0, 0, 3, 1));
    applyStimulus("allwait_hold", idle, ex(0, 0, 32'h0, 0, 0, 3, 1));
    applyStimulus("done2_wake", st(0, 0, 0, 0, 0, 0, 0, 1, 2), ex(1, 2, 32'h820, 1, 1, 0, 0));
    applyStimulus("done1_miss1_same", st(0, 0, 0, 0, 1, 1, 32'h500, 1, 1), ex(1, 2, 32'h820, 1, 0, 0, 0));
    applyStimulus("miss2_allwait", st(0, 0, 0, 0, 1, 2, 32'h830, 0, 0), ex(0, 2, 32'h0, 0, 0, 0, 1));
    applyStimulus("done1_wake", st(0, 0, 0, 0, 0, 0, 0, 1, 1), ex(1, 1, 32'h500, 1, 1, 2, 0));
    applyStimulus("redir_adv", st(1, 1, 1, 32'h80, 0, 0, 0, 0, 0), ex(1, 1, 32'h80, 1, 0, 2, 0));
    applyStimulus("adv_after_redir", st(1, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 32'h84, 1, 0, 2, 0));
    applyStimulus("redir_other", st(1, 1, 0, 32'h200, 0, 0, 0, 0, 0), ex(1, 1, 32'h88, 1, 0, 2, 0));
    applyStimulus("done0_miss1", st(0, 0, 0, 0, 1, 1, 32'h90, 1, 0), ex(1, 0, 32'h200, 1, 1, 1, 0));
    applyStimulus("done_ready_ignored", st(1, 0, 0, 0, 0, 0, 0, 1, 0), ex(1, 0, 32'h204, 1, 0, 1, 0));
    applyStimulus("miss_waiting_pc", st(0, 0, 0, 0, 1, 2, 32'h900, 0, 0), ex(1, 0, 32'h204, 1, 0, 1, 0));
    applyStimulus("done2_miss0", st(0, 0, 0, 0, 1, 0, 32'h300, 1, 2), ex(1, 2, 32'h900, 1, 1, 0, 0));

    applyStimulus("midreset", idle, ex(1, 0, 32'h0, 1, 0, 0, 0));
    nReset = 1'b1;
    @(negedge clk);
    nReset = 1'b0;

    e = ex(1, 0, 32'h4, 1, 0, 0, 0);
    e.chkStall = 1'b1;
    e.stall = 64'h0;
    applyStimulus("post_reset_miss3", st(1, 0, 0, 0, 1, 3, 32'hC10, 0, 0), e);
    for (int k = 1; k <= 10; k++) begin
      e = ex(1, 0, 32'h4, 1, 0, 0, 0);
      e.chkStall = 1'b1;
      e.stall = {16'(k), 48'h0};
      applyStimulus($sformatf("stall3_%0d", k), idle, e);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Parametrised hardware-thread scheduler for the multithreaded RISC-V core, generalising the fixed four-thread switch-on-miss logic to NUM_THREADS threads.
- Holds a PC and a READY/WAIT state for every thread.
- Each cycle, picks the thread the fetch stage issues from.
- On any instruction or data miss, switches round-robin to the next READY thread and signals a flush.
- Sits between the IF stage, the branch/jump resolution in ID/EX, and the cache/memory controllers that report miss and done events.

## Interface
- NUM_THREADS, 4, number of hardware threads (2..16)
- XLEN, 32, PC width
- RESET_PC, 32'h0000_0000, start PC of thread 0
- PC_STRIDE, 32'h0000_0400, start-PC spacing between threads
- clk  in  1  system clock, rising edge
- nReset  in  1  asynchronous reset, active-high (1 = in reset)
- advance  in  1  fetch accepted this cycle; current thread PC += 4
- redirect_valid  in  1  branch/jump taken
- redirect_tid  in  TID_W  thread being redirected
- redirect_pc  in  XLEN  redirect target
- miss_valid  in  1  instruction or data miss reported
- miss_tid  in  TID_W  missing thread
- miss_pc  in  XLEN  replay PC of the missing instruction
- done_valid  in  1  outstanding miss resolved
- done_tid  in  TID_W  thread whose miss resolved
- fetch_valid  out  1  fetch_pc/fetch_tid are issuable
- fetch_tid  out  TID_W  selected thread
- fetch_pc  out  XLEN  PC to fetch
- switch_pulse  out  1  one-cycle pulse: selected thread changed
- flush_tid  out  TID_W  thread whose in-flight instructions must be flushed
- all_waiting  out  1  no thread READY

## Operation
- Width rule: TID_W = max(1, $clog2(NUM_THREADS)).
- Per-thread state is READY or WAIT. Reset puts every thread in READY with pc[t] = RESET_PC + t*PC_STRIDE, truncated to XLEN.
- Each cycle, events update pc[t] in this priority, highest first:
  - miss on t: pc = miss_pc, state = WAIT
  - redirect on t: pc = redirect_pc
  - advance with t == fetch_tid and fetch_valid: pc += 4, wrapping modulo 2^XLEN
- done on t sets state = READY, unless a miss on the same t arrives in the same cycle; the miss wins and the state stays WAIT.
- done for a thread already READY is ignored. miss for a thread already WAIT updates pc only.
- Selection is computed from next-state:
  - If the current thread is still READY, keep it (no switch).
  - Otherwise, scan tid+1, tid+2, … modulo NUM_THREADS and take the first READY thread.
  - If no thread is READY: fetch_valid = 0, fetch_tid holds, all_waiting = 1.
- Leaving the all-waiting state selects the lowest-distance READY thread from the held fetch_tid. This counts as a switch only if the tid differs.
- switch_pulse = 1 and flush_tid = old tid in the cycle after a selection change.
- A redirect_tid or miss_tid of NUM_THREADS or more, for non-power-of-two NUM_THREADS, is ignored.

## Timing
- Reset values: fetch_valid 1, fetch_tid 0, fetch_pc RESET_PC, switch_pulse 0, flush_tid 0, all_waiting 0.
- All outputs are registered.
- Event → output latency is 1 cycle:
  - miss in cycle n: new fetch_tid/fetch_pc in cycle n+1.
  - done in cycle m while all_waiting: fetch_valid = 1 in cycle m+1.
- Redirect of the current thread in cycle n: fetch_pc = redirect_pc in n+1, same tid, switch_pulse 0.
- Asserting nReset mid-operation clears all state immediately. The first issue after release is thread 0 at RESET_PC.

## Configuration
- THREAD_STALL_COUNT_EN defined:
  - Adds output stall_count, NUM_THREADS×16 bits, packed, thread 0 in the LSBs.
  - Each counter increments every cycle its thread is WAIT and saturates at 16'hFFFF.
  - Counters clear on reset only.
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Package mt_pkg:
  - thread_state_e (READY, WAIT)
  - TID_W function
  - PC increment constant 4
- One sub-module, rr_thread_picker: combinational round-robin search. Inputs are ready vector and start index; outputs are found flag and index.

## Test plan
- Reset, NUM_THREADS=4, advance held 1 → fetch_tid 0, fetch_pc 0x0, 0x4, 0x8 on successive cycles.
- miss_valid, tid 0, miss_pc 0x10 → next cycle fetch_tid 1, fetch_pc 0x400, switch_pulse 1, flush_tid 0. Then done tid 0; after thread 1 misses → fetch_tid 2.
- Miss all 4 threads → fetch_valid 0, all_waiting 1. Then done tid 2 → next cycle fetch_valid 1, fetch_tid 2, fetch_pc = its miss_pc.
- Same cycle: done tid 1 and miss tid 1 (pc 0x500) → thread 1 stays WAIT, pc 0x500.
- redirect tid 0 to 0x80 together with advance → next fetch_pc 0x80, not 0x84.
- THREAD_STALL_COUNT_EN, thread 3 WAIT for 10 cycles → stall_count[63:48] = 10.
